// File: rtl/cga_pkg.sv
// Shared definitions for the CGA capture path: RGBI bit layout, default CGA
// timing, and the line-lock state encoding.
package cga_pkg;

    localparam int RGBI_B = 0;
    localparam int RGBI_G = 1;
    localparam int RGBI_R = 2;
    localparam int RGBI_I = 3;

    // Positions of the syncs in the synchronised input bundle {vsync, hsync, rgbi}
    localparam int SYNC_HS_BIT = 4;
    localparam int SYNC_VS_BIT = 5;

    localparam logic [9:0] CGA_H_TOTAL  = 10'd912;
    localparam logic [8:0] CGA_V_TOTAL  = 9'd262;
    localparam logic [9:0] CGA_H_START  = 10'd48;
    localparam logic [9:0] CGA_H_ACTIVE = 10'd640;
    localparam logic [8:0] CGA_V_START  = 9'd36;
    localparam logic [8:0] CGA_V_ACTIVE = 9'd200;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/cga_sync_edge.sv
// Three-flop synchroniser for an asynchronous bundle; every bit shares the same
// stages so relative alignment survives. Rising edges are flagged on the top E bits.
module cga_sync_edge #(
    parameter int W = 6,
    parameter int E = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [E-1:0] rise
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Edge is flagged one stage early so counters line up with s3 data
    assign rise = s2[W-1 -: E] & ~s3[W-1 -: E];
    assign q    = s3;

endmodule

// File: rtl/cga_capture_port.sv
// Captures an external TTL CGA RGBI stream, measures line timing for lock and
// regenerates a display-enable window around registered, aligned video/syncs.
module cga_capture_port
    import cga_pkg::*;
#(
    parameter logic [9:0] H_START    = CGA_H_START,
    parameter logic [9:0] H_ACTIVE   = CGA_H_ACTIVE,
    parameter logic [8:0] V_START    = CGA_V_START,
    parameter logic [8:0] V_ACTIVE   = CGA_V_ACTIVE,
    parameter logic [3:0] H_TOL      = 4'd2,
    parameter logic [3:0] LOCK_LINES = 4'd8,
    parameter logic [3:0] LOSS_LINES = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ext_video,
    input  logic       ext_hsync,
    input  logic       ext_vsync,
    output logic [3:0] video,
    output logic       display_enable,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] line_period
);

    localparam int SYNC_W = 6;

    logic [SYNC_W-1:0] sync_q;
    logic [1:0]        sync_rise;
    logic              hs_edge;
    logic              vs_edge;

    logic [9:0]  hcount;
    logic [8:0]  vcount;
    logic [9:0]  stored;
    logic [3:0]  cnt;
    lock_state_t state;

    logic [10:0] meas;
    logic        match;
    logic        timeout;
    logic        h_in;
    logic        v_in;
    logic        de_next;

    cga_sync_edge #(
        .W(SYNC_W),
        .E(2)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({ext_vsync, ext_hsync, ext_video}),
        .q    (sync_q),
        .rise (sync_rise)
    );

    assign hs_edge = sync_rise[0];
    assign vs_edge = sync_rise[1];

    always_comb begin
        meas    = {1'b0, hcount} + 11'd1;
        match   = abs_diff(meas, {1'b0, stored}) <= {7'd0, H_TOL};
        timeout = (hcount == 10'h3FF);
        h_in    = ({1'b0, hcount} >= {1'b0, H_START}) &&
                  ({1'b0, hcount} <  ({1'b0, H_START} + {1'b0, H_ACTIVE}));
        v_in    = ({1'b0, vcount} >= {1'b0, V_START}) &&
                  ({1'b0, vcount} <  ({1'b0, V_START} + {1'b0, V_ACTIVE}));
        de_next = locked & h_in & v_in & ~timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            line_period <= '0;
        end else begin
            if (hs_edge) begin
                hcount      <= '0;
                line_period <= meas[9:0];
            end else if (hcount != 10'h3FF) begin
                hcount <= hcount + 10'd1;
            end
            // vsync wins over a coincident hsync so the frame restarts at line 0
            if (vs_edge) begin
                vcount <= '0;
            end else if (hs_edge && vcount != 9'h1FF) begin
                vcount <= vcount + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEARCH;
            cnt    <= '0;
            stored <= '0;
            locked <= 1'b0;
        end else if (timeout) begin
            // hsync has gone away; this also swallows an edge that lands on 1023
            state  <= SEARCH;
            cnt    <= '0;
            locked <= 1'b0;
        end else if (hs_edge) begin
            case (state)
                SEARCH: begin
                    stored <= meas[9:0];
                    cnt    <= '0;
                    state  <= VERIFY;
                end
                VERIFY: begin
                    if (match) begin
                        if (cnt == LOCK_LINES - 4'd1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        stored <= meas[9:0];
                        cnt    <= '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        stored <= meas[9:0];
                        cnt    <= '0;
                    end else if (cnt == LOSS_LINES - 4'd1) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video          <= '0;
            display_enable <= 1'b0;
            hsync          <= 1'b0;
            vsync          <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            video          <= de_next ? sync_q[RGBI_I:RGBI_B] : 4'h0;
            display_enable <= de_next;
            hsync          <= sync_q[SYNC_HS_BIT];
            vsync          <= sync_q[SYNC_VS_BIT];
            frame_start    <= sync_q[SYNC_VS_BIT] & ~vsync;
        end
    end

endmodule

// File: tb/tb_cga_capture_port.sv
// Bench for cga_capture_port: directed CGA lines with a per-line expected record
// that a monitor pops on each rising edge of the registered hsync output.
module tb_cga_capture_port;
  import cga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ext_video;
  logic       ext_hsync;
  logic       ext_vsync;
  logic [3:0] video;
  logic       display_enable;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic       locked;
  logic [9:0] line_period;

  // Short vertical window keeps whole frames out of the run time
  cga_capture_port #(
    .V_START (9'd3),
    .V_ACTIVE(9'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ext_video     (ext_video),
    .ext_hsync     (ext_hsync),
    .ext_vsync     (ext_vsync),
    .video         (video),
    .display_enable(display_enable),
    .hsync         (hsync),
    .vsync         (vsync),
    .frame_start   (frame_start),
    .locked        (locked),
    .line_period   (line_period)
  );

  always #5 clk = ~clk;

  // Expectations at one output hsync rise: lock/period after that edge, DE
  // count and first DE pixel of the line before it, frame_start pulses.
  typedef struct packed {
    logic        lk;
    logic        per_ok;
    logic [9:0]  per;
    logic [10:0] de;
    logic [3:0]  fp;
    logic [1:0]  fs;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam int NOM = int'(CGA_H_TOTAL);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_video"}, int'(video), 0);
    check({tag, "_de"}, int'(display_enable), 0);
    check({tag, "_hsync"}, int'(hsync), 0);
    check({tag, "_vsync"}, int'(vsync), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_line_period"}, int'(line_period), 0);
  endtask

  // One line: 16-clk hsync pulse (optionally with vsync), background pixel 5,
  // optional 1-clk pixel A at active pixel 0. exp_per < 0 means not checked.
  task automatic send_line(input int period, input bit vs, input bit pulse,
                           input bit exp_lk, input int exp_per, input int exp_de,
                           input logic [3:0] exp_fp);
    rec_t r;
    r.lk     = exp_lk;
    r.per_ok = (exp_per >= 0);
    r.per    = (exp_per >= 0) ? 10'(exp_per) : 10'd0;
    r.de     = 11'(exp_de);
    r.fp     = exp_fp;
    r.fs     = vs ? 2'd1 : 2'd0;
    exp_q.push_back(r);
    for (int i = 0; i < period; i++) begin
      @(negedge clk);
      ext_hsync = (i < 16);
      ext_vsync = vs && (i < 16);
      ext_video = (pulse && i == 48) ? 4'hA : 4'h5;
    end
  endtask

  int         mon_de;
  int         mon_fs;
  int         mon_line;
  logic [3:0] mon_fp;
  bit         mon_leak;
  bit         mon_prev_hs;
  bit         mon_prev_de;
  rec_t       mon_r;

  initial begin
    mon_line = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_de = 0; mon_fs = 0; mon_fp = 4'h0; mon_leak = 0;
        mon_prev_hs = 0; mon_prev_de = 0;
      end else begin
        if (frame_start) mon_fs++;
        if (display_enable) begin
          if (!mon_prev_de) mon_fp = video;
          mon_de++;
        end else if (video != 4'h0) begin
          mon_leak = 1;
        end
        if (hsync && !mon_prev_hs) begin
          mon_line++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL line%0d_unexpected: output hsync with no expected record", mon_line);
          end else begin
            mon_r = exp_q.pop_front();
            check($sformatf("line%0d_locked", mon_line), int'(locked), int'(mon_r.lk));
            if (mon_r.per_ok)
              check($sformatf("line%0d_period", mon_line), int'(line_period), int'(mon_r.per));
            check($sformatf("line%0d_de_count", mon_line), mon_de, int'(mon_r.de));
            check($sformatf("line%0d_first_pixel", mon_line), int'(mon_fp), int'(mon_r.fp));
            check($sformatf("line%0d_frame_start", mon_line), mon_fs, int'(mon_r.fs));
            check($sformatf("line%0d_video_leak", mon_line), int'(mon_leak), 0);
          end
          mon_de = 0; mon_fs = 0; mon_fp = 4'h0; mon_leak = 0;
        end
        mon_prev_hs = hsync;
        mon_prev_de = display_enable;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    ext_video = 4'hF;
    ext_hsync = 1'b1;
    ext_vsync = 1'b1;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    ext_video = 4'h0;
    ext_hsync = 1'b0;
    ext_vsync = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Acquire: first edge stores a short bogus period, then 8 matches lock
    send_line(NOM, 0, 0, 0, -1, 0, 4'h0);
    for (int k = 2; k <= 9; k++) send_line(NOM, 0, 0, 0, NOM, 0, 4'h0);
    send_line(NOM, 0, 0, 1, NOM, 0, 4'h0);
    // Coincident hsync/vsync: lines 14..17 sit in the vertical window
    send_line(NOM, 1, 0, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 0, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 0, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 1, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 0, 1, NOM, 640, 4'hA);
    for (int k = 16; k <= 18; k++) send_line(NOM, 0, 0, 1, NOM, 640, 4'h5);

    // Jitter within tolerance, one outlier, then four outliers drop lock
    send_line(911, 0, 0, 1, NOM, 0, 4'h0);
    send_line(913, 0, 0, 1, 911, 0, 4'h0);
    send_line(911, 0, 0, 1, 913, 0, 4'h0);
    send_line(913, 0, 0, 1, 911, 0, 4'h0);
    send_line(920, 0, 0, 1, 913, 0, 4'h0);
    send_line(NOM, 0, 0, 1, 920, 0, 4'h0);
    send_line(920, 0, 0, 1, NOM, 0, 4'h0);
    for (int k = 26; k <= 28; k++) send_line(920, 0, 0, 1, 920, 0, 4'h0);
    send_line(NOM, 0, 0, 0, 920, 0, 4'h0);

    // Relock, then lose hsync for well over 1023 clocks
    for (int k = 30; k <= 37; k++) send_line(NOM, 0, 0, 0, NOM, 0, 4'h0);
    send_line(1200, 0, 0, 1, NOM, 0, 4'h0);
    // Window lines 42..45 while unlocked must stay dark
    send_line(NOM, 1, 0, 0, -1, 0, 4'h0);
    for (int k = 40; k <= 47; k++) send_line(NOM, 0, 0, 0, NOM, 0, 4'h0);
    send_line(NOM, 1, 0, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 0, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 0, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 1, 1, NOM, 0, 4'h0);
    send_line(NOM, 0, 0, 1, NOM, 640, 4'hA);
    for (int k = 53; k <= 54; k++) send_line(NOM, 0, 0, 1, NOM, 640, 4'h5);
    send_line(100, 0, 0, 1, NOM, 640, 4'h5);

    // Reset mid-stream while locked: outputs clear without waiting for a clock
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("pending_records", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_locked", int'(locked), 0);
    check("post_reset_period", int'(line_period), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cga_capture_port.md
Name: cga_capture_port

Overview:
Input-side counterpart of the CGA-to-HDMI output port. It samples an external TTL CGA RGBI video stream (4-bit video, hsync, vsync) in the pixel clock domain and synchronises it. It measures line timing to decide lock, then regenerates a display-enable window. It emits an aligned, registered RGBI + hsync/vsync/display_enable stream plus status, ready to feed the HDMI output path or a frame buffer writer.

Parameters:
H_START, 10'd48, pixel clocks from synced hsync rising edge to first active pixel
H_ACTIVE, 10'd640, active pixels per line
V_START, 9'd36, lines from synced vsync rising edge to first active line
V_ACTIVE, 9'd200, active lines per frame
H_TOL, 4'd2, allowed |line period delta| in clocks for a line to count as matching
LOCK_LINES, 4'd8, consecutive matching lines needed to assert lock
LOSS_LINES, 4'd4, consecutive mismatching lines in LOCKED that drop lock

Ports:
clk  in  1  pixel clock (14.318 MHz)
rst_n  in  1  asynchronous reset, active low
ext_video  in  4  asynchronous RGBI from connector: [3]=I, [2]=R, [1]=G, [0]=B
ext_hsync  in  1  asynchronous hsync, active high
ext_vsync  in  1  asynchronous vsync, active high
video  out  4  captured RGBI; forced 0 outside the DE window
display_enable  out  1  active-window flag, gated by locked
hsync  out  1  synchronised hsync, aligned with video
vsync  out  1  synchronised vsync, aligned with video
frame_start  out  1  one-cycle pulse on synced vsync rising edge
locked  out  1  line-timing lock status
line_period  out  10  last measured line length in clocks

Behaviour:
- Reset (rst_n low, async): all outputs 0, all counters 0, FSM = SEARCH, stored period 0.
- Sync: all 6 ext_* bits go through the same 2-flop synchroniser, so relative alignment is preserved. A third flop stage s3 is used for edge detect. Edge = s2 & ~s3.
- Output register: video/hsync/vsync/display_enable are registered from s3-aligned data. Fixed latency from ext pin to output is 4 clk. frame_start is registered in the same cycle as the vsync output.
- hcount (10b): on an hsync edge it loads 0. Otherwise it increments and saturates at 1023.
- vcount (9b):
  - On an hsync edge it increments, saturating at 511.
  - On a vsync edge it loads 0.
  - If both edges occur in the same cycle, vsync wins and vcount = 0.
- Period: on each hsync edge, line_period <= hcount + 1.
- DE = locked & (H_START <= hcount < H_START+H_ACTIVE) & (V_START <= vcount < V_START+V_ACTIVE). Comparisons use 11-bit sums so there is no wrap.
- Lock FSM. Updates only on hsync edges, except for the timeout rule. match = |hcount+1 - stored| <= H_TOL.
  - SEARCH: on an edge, store the period, clear cnt, go to VERIFY.
  - VERIFY:
    - match: cnt++. When cnt reaches LOCK_LINES-1 on a match, go to LOCKED, set locked=1, clear cnt.
    - mismatch: store the new period, clear cnt, stay in VERIFY.
  - LOCKED:
    - match: cnt = 0, and the stored period is updated.
    - mismatch: cnt++. On the LOSS_LINES-th consecutive mismatch, go to SEARCH and set locked=0.
  - Timeout: if hcount reaches 1023 (hsync lost) in any state, go to SEARCH the next cycle, set locked=0, and force DE 0.
- Loss of lock mid-line: DE drops the next cycle. Video reads 0 from then on.
- A missing vsync does not affect lock. vcount saturates and DE stays 0 until the next vsync.

Decomposition:
- Shared package cga_pkg: RGBI bit indices, CGA timing defaults (912 clk/line, 262 lines, H/V start and active values), and the lock FSM state enum {SEARCH, VERIFY, LOCKED}.
- One natural sub-module: cga_sync_edge, a parameterised-width 3-flop synchroniser with rising-edge outputs. It is instantiated once for the 6-bit input bundle.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately. After release, locked=0 until 8 good lines.
- Nominal 912-clk lines, 262-line frames -> locked=1 after the 8th matching hsync edge; line_period=912. Per active line DE is high for exactly 640 clk, with the first DE 4+48 clk after the ext_hsync rise. 200 DE lines per frame.
- Latency/alignment: ext_video=4'hA pulse of 1 clk at active pixel 0 -> video=4'hA coincident with the first DE=1 cycle, 4 clk after input. Video=0 while DE=0.
- Jitter: line periods alternating 911/913 -> lock holds. One line of 920 then 912 -> lock holds, cnt resets. 4 consecutive 920 lines -> locked=0 after the 4th edge.
- Timeout: stop hsync for 1100 clk -> locked=0 and DE=0 once hcount reaches 1023. Resuming 912-clk lines relocks after 8 lines.
- Simultaneous hsync/vsync edge -> vcount=0, frame_start pulses once, the next hsync gives vcount=1.
